// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM-stage data port (master) and dmem_responder (slave).
// Request side is a valid/ready handshake; the response is held until RSP_READY.
interface dmem_responder_if #(
    parameter int ADDR_W = 14
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WE;
    logic [ADDR_W+1:0] REQ_ADDR;
    logic [1:0]        REQ_BYTE_SEL;
    logic              REQ_SIGN;
    logic [31:0]       REQ_WDATA;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [31:0]       RSP_RDATA;
    logic              RSP_ERR;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_BYTE_SEL, REQ_SIGN, REQ_WDATA, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_BYTE_SEL, REQ_SIGN, REQ_WDATA, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
    );
endinterface

// File: rtl/dmem_responder.sv
// Slow data-memory responder: WAIT_CYCLES wait states, byte/half/word steering, load extension.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses return RSP_ERR=1 and never write.
module dmem_responder #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    dmem_responder_if.slave bus
);
    localparam int         AW       = ADDR_W + 2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic          we_q, sign_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    sel_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rd_word_q;
    logic [31:0]   mem [2**ADDR_W];

    logic              accept, enter_resp;
    logic              op_we;
    logic [AW-1:0]     op_addr;
    logic [1:0]        op_sel;
    logic [31:0]       op_wdata;
    logic [ADDR_W-1:0] op_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              op_misalign, rsp_misalign;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] sel, input logic [1:0] lo);
        return (sel == 2'b01 && lo[0]) || (sel[1] && lo != 2'b00);
    endfunction
    assign op_misalign  = misaligned(op_sel, op_addr[1:0]);
    assign rsp_misalign = misaligned(sel_q, addr_q[1:0]);
`else
    assign op_misalign  = 1'b0;
    assign rsp_misalign = 1'b0;
`endif

    assign accept = bus.REQ_VALID && (state_q == IDLE);

    // With WAIT_CYCLES==0 the array is touched on the accept edge, before the capture registers load.
    assign op_we    = (state_q == IDLE) ? bus.REQ_WE       : we_q;
    assign op_addr  = (state_q == IDLE) ? bus.REQ_ADDR     : addr_q;
    assign op_sel   = (state_q == IDLE) ? bus.REQ_BYTE_SEL : sel_q;
    assign op_wdata = (state_q == IDLE) ? bus.REQ_WDATA    : wdata_q;
    assign op_idx   = op_addr[AW-1:2];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (accept) begin
                if (WAIT_CYCLES == 0) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
                  else               cnt_d   = cnt_q - 4'd1;
            RESP: if (bus.RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = op_wdata;
        case (op_sel)
            2'b00: begin
                wr_be   = 4'b0001 << op_addr[1:0];
                wr_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q    <= bus.REQ_WE;
            addr_q  <= bus.REQ_ADDR;
            sel_q   <= bus.REQ_BYTE_SEL;
            sign_q  <= bus.REQ_SIGN;
            wdata_q <= bus.REQ_WDATA;
        end
    end

    // NOTE: the array has no reset; only the write strobe is qualified by RST so a dropped store never lands.
    always_ff @(posedge CLK) begin
        if (enter_resp && op_we && !op_misalign && !RST) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) mem[op_idx][8*l +: 8] <= wr_data[8*l +: 8];
            end
        end
        if (enter_resp) rd_word_q <= mem[op_idx];
    end

    assign ld_byte = rd_word_q[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = rd_word_q[{addr_q[1], 4'b0000} +: 16];

    // REQ_SIGN=1 selects zero-extension (funct3[2] of LBU/LHU).
    always_comb begin
        ld_data = rd_word_q;
        case (sel_q)
            2'b00:   ld_data = sign_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = sign_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    assign bus.REQ_READY = (state_q == IDLE);
    assign bus.RSP_VALID = (state_q == RESP);
    assign bus.RSP_ERR   = (state_q == RESP) && rsp_misalign;
    assign bus.RSP_RDATA = ((state_q == RESP) && !we_q && !rsp_misalign) ? ld_data : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=14, WAIT_CYCLES=2); honours MISALIGN_TRAP_EN.
// Inputs are driven and outputs sampled on the falling edge, away from the active posedge.
module tb_dmem_responder;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic CLK = 1'b0;
    logic RST;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 CLK = ~CLK;

    dmem_responder_if #(.ADDR_W(14)) bus ();

    dmem_responder #(.ADDR_W(14), .WAIT_CYCLES(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    // One complete request/response with RSP_READY held high. lat counts falling edges
    // from the handshake cycle until RSP_VALID is seen.
    task automatic xact(input logic we, input logic [15:0] addr, input logic [1:0] sel,
                        input logic sign, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        int guard = 0;
        @(negedge CLK);
        bus.REQ_WE       = we;
        bus.REQ_ADDR     = addr;
        bus.REQ_BYTE_SEL = sel;
        bus.REQ_SIGN     = sign;
        bus.REQ_WDATA    = wdata;
        bus.REQ_VALID    = 1'b1;
        bus.RSP_READY    = 1'b1;
        while (bus.REQ_READY !== 1'b1 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (guard == 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL req_timeout addr=%h: REQ_READY got %b required 1", addr, bus.REQ_READY);
        end
        lat = 0;
        do begin
            @(negedge CLK);
            bus.REQ_VALID = 1'b0;
            lat++;
        end while (bus.RSP_VALID !== 1'b1 && lat < 40);
        if (bus.RSP_VALID !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL rsp_timeout addr=%h: RSP_VALID got %b required 1", addr, bus.RSP_VALID);
        end
        rdata = bus.RSP_RDATA;
        err   = bus.RSP_ERR;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        bus.REQ_VALID = 1'b0; bus.REQ_WE = 1'b0; bus.REQ_ADDR = '0; bus.REQ_BYTE_SEL = SZ_W;
        bus.REQ_SIGN = 1'b0; bus.REQ_WDATA = '0; bus.RSP_READY = 1'b0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (bus.REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b required 1", bus.REQ_READY); end
        tests_run++;
        if (bus.RSP_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b required 0", bus.RSP_VALID); end
        tests_run++;
        if (bus.RSP_RDATA !== 32'h0) begin tests_failed++; $display("FAIL reset_rsp_rdata: got %h required 00000000", bus.RSP_RDATA); end
        tests_run++;
        if (bus.RSP_ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err: got %b required 0", bus.RSP_ERR); end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic err; int lat;
        xact(1'b1, 16'h0010, SZ_W, 1'b0, 32'hDEADBEEF, rd, err, lat);
        tests_run++;
        if (lat != 3) begin tests_failed++; $display("FAIL store_latency: got %0d required 3", lat); end
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL store_rdata: got %h required 00000000", rd); end
        xact(1'b0, 16'h0010, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (lat != 3) begin tests_failed++; $display("FAIL load_latency: got %0d required 3", lat); end
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_word: got %h required deadbeef", rd); end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic err; int lat;
        xact(1'b1, 16'h0013, SZ_B, 1'b0, 32'hFFFFFF7F, rd, err, lat);
        xact(1'b0, 16'h0013, SZ_B, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h0000007F) begin tests_failed++; $display("FAIL lb_0x13: got %h required 0000007f", rd); end
        xact(1'b1, 16'h0011, SZ_B, 1'b0, 32'h00000080, rd, err, lat);
        xact(1'b0, 16'h0011, SZ_B, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_0x11: got %h required ffffff80", rd); end
        xact(1'b0, 16'h0011, SZ_B, 1'b1, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h00000080) begin tests_failed++; $display("FAIL lbu_0x11: got %h required 00000080", rd); end
        xact(1'b0, 16'h0010, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h7FAD80EF) begin tests_failed++; $display("FAIL lw_after_bytes: got %h required 7fad80ef", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic err; int lat;
        xact(1'b1, 16'h0020, SZ_W, 1'b0, 32'h0, rd, err, lat);
        xact(1'b1, 16'h0022, SZ_H, 1'b0, 32'h5555BEEF, rd, err, lat);
        xact(1'b0, 16'h0022, SZ_H, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'hFFFFBEEF) begin tests_failed++; $display("FAIL lh_0x22: got %h required ffffbeef", rd); end
        xact(1'b0, 16'h0022, SZ_H, 1'b1, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h0000BEEF) begin tests_failed++; $display("FAIL lhu_0x22: got %h required 0000beef", rd); end
        xact(1'b0, 16'h0020, SZ_H, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h00000000) begin tests_failed++; $display("FAIL lh_0x20: got %h required 00000000", rd); end
        xact(1'b0, 16'h0020, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'hBEEF0000) begin tests_failed++; $display("FAIL lw_after_half: got %h required beef0000", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic err; int lat;
        int guard = 0;
        @(negedge CLK);
        bus.REQ_WE = 1'b0; bus.REQ_ADDR = 16'h0010; bus.REQ_BYTE_SEL = SZ_W; bus.REQ_SIGN = 1'b0;
        bus.REQ_VALID = 1'b1; bus.RSP_READY = 1'b0;
        do begin
            @(negedge CLK);
            bus.REQ_VALID = 1'b0;
            guard++;
        end while (bus.RSP_VALID !== 1'b1 && guard < 20);
        // Competing store held during RESP; it must not be taken.
        bus.REQ_WE = 1'b1; bus.REQ_WDATA = 32'hFFFFFFFF; bus.REQ_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            tests_run++;
            if (bus.RSP_VALID !== 1'b1) begin tests_failed++; $display("FAIL bp_rsp_valid[%0d]: got %b required 1", i, bus.RSP_VALID); end
            tests_run++;
            if (bus.RSP_RDATA !== 32'h7FAD80EF) begin tests_failed++; $display("FAIL bp_rsp_rdata[%0d]: got %h required 7fad80ef", i, bus.RSP_RDATA); end
            tests_run++;
            if (bus.REQ_READY !== 1'b0) begin tests_failed++; $display("FAIL bp_req_ready[%0d]: got %b required 0", i, bus.REQ_READY); end
        end
        bus.RSP_READY = 1'b1;
        @(negedge CLK);
        bus.REQ_VALID = 1'b0;
        tests_run++;
        if (bus.RSP_VALID !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid: got %b required 0", bus.RSP_VALID); end
        tests_run++;
        if (bus.REQ_READY !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b required 1", bus.REQ_READY); end
        xact(1'b0, 16'h0010, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h7FAD80EF) begin tests_failed++; $display("FAIL bp_no_reaccept: got %h required 7fad80ef", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic err; int lat;
        xact(1'b1, 16'h0040, SZ_W, 1'b0, 32'h0, rd, err, lat);
        @(negedge CLK);
        bus.REQ_WE = 1'b1; bus.REQ_ADDR = 16'h0040; bus.REQ_BYTE_SEL = SZ_W;
        bus.REQ_WDATA = 32'h12345678; bus.REQ_VALID = 1'b1; bus.RSP_READY = 1'b1;
        @(negedge CLK);
        bus.REQ_VALID = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (bus.RSP_VALID !== 1'b0) begin tests_failed++; $display("FAIL rst_wait_state: RSP_VALID got %b required 0", bus.RSP_VALID); end
        // Reset lands on the edge that would otherwise commit the store.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            tests_run++;
            if (bus.RSP_VALID !== 1'b0) begin tests_failed++; $display("FAIL rst_no_rsp[%0d]: got %b required 0", i, bus.RSP_VALID); end
        end
        xact(1'b0, 16'h0040, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL rst_store_dropped: got %h required 00000000", rd); end
        tests_run++;
        if (lat != 3) begin tests_failed++; $display("FAIL rst_latency_after: got %0d required 3", lat); end
    endtask

    task automatic test_size_edges();
        logic [31:0] rd; logic err; int lat;
        xact(1'b0, 16'h0010, 2'b11, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h7FAD80EF) begin tests_failed++; $display("FAIL sel11_as_word: got %h required 7fad80ef", rd); end
`ifdef MISALIGN_TRAP_EN
        xact(1'b0, 16'h0042, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL mis_lw_err: got %b required 1", err); end
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL mis_lw_rdata: got %h required 00000000", rd); end
        xact(1'b1, 16'h0041, SZ_H, 1'b0, 32'h0000AAAA, rd, err, lat);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL mis_sh_err: got %b required 1", err); end
        tests_run++;
        if (lat != 3) begin tests_failed++; $display("FAIL mis_latency: got %0d required 3", lat); end
        xact(1'b0, 16'h0040, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL mis_sh_no_write: got %h required 00000000", rd); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL aligned_err: got %b required 0", err); end
`else
        xact(1'b0, 16'h0012, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h7FAD80EF) begin tests_failed++; $display("FAIL lw_low_bits_ignored: got %h required 7fad80ef", rd); end
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL lw_err_tied: got %b required 0", err); end
        xact(1'b0, 16'h0023, SZ_H, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'hFFFFBEEF) begin tests_failed++; $display("FAIL lh_bit0_ignored: got %h required ffffbeef", rd); end
        xact(1'b1, 16'h0041, SZ_H, 1'b0, 32'h0000AAAA, rd, err, lat);
        xact(1'b0, 16'h0040, SZ_W, 1'b0, 32'h0, rd, err, lat);
        tests_run++;
        if (rd !== 32'h0000AAAA) begin tests_failed++; $display("FAIL sh_bit0_ignored: got %h required 0000aaaa", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_lanes();
        test_half();
        test_backpressure();
        test_reset_mid_wait();
        test_size_edges();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
